// File: rtl/twiddle_mult_108.sv
// Twiddle multiplier between the column and row DFT stages of the 4x27 FFT.
// Generates (row*col) mod TW_N ROM addresses and applies the Q10 twiddle with round/saturate.
module twiddle_mult_108 #(
   parameter int DW      = 16,
   parameter int ROWS    = 4,
   parameter int COLS    = 27,
   parameter int TW_N    = 108,
   parameter int TW_LAT  = 0,
   parameter int INVERSE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   output logic [10:0]          tw_addr,
   input  logic signed [17:0]   tw_re,
   input  logic signed [17:0]   tw_im,
   output logic                 out_valid,
   output logic                 out_sof,
   output logic                 out_last,
   output logic signed [DW-1:0] out_re,
   output logic signed [DW-1:0] out_im
);
   localparam int AW = 11;
   localparam int CW = $clog2(COLS + 1);
   localparam int RW = $clog2(ROWS + 1);
   localparam int PW = DW + 20;
   localparam logic signed [PW-1:0] SMAX = PW'((64'sd1 <<< (DW - 1)) - 64'sd1);
   localparam logic signed [PW-1:0] SMIN = -SMAX - PW'(1);

   function automatic logic signed [DW-1:0] rnd_sat(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      r = (p + PW'(512)) >>> 10;
      if (r > SMAX)      return SMAX[DW-1:0];
      else if (r < SMIN) return SMIN[DW-1:0];
      else               return r[DW-1:0];
   endfunction

   logic          active;
   logic [RW-1:0] row, row_cur;
   logic [CW-1:0] col, col_cur;
   logic [AW-1:0] acc, acc_cur, acc_step;
   logic          start, take, col_wrap, frame_end;

   // An in_sof sample always starts at index 0, even mid-frame.
   always_comb begin
      start     = in_valid && in_sof;
      take      = in_valid && (in_sof || active);
      row_cur   = start ? '0 : row;
      col_cur   = start ? '0 : col;
      acc_cur   = start ? '0 : acc;
      col_wrap  = (col_cur == CW'(COLS - 1));
      frame_end = col_wrap && (row_cur == RW'(ROWS - 1));
      acc_step  = acc_cur + AW'(row_cur);
      if (acc_step >= AW'(TW_N)) acc_step = acc_step - AW'(TW_N);
   end

   assign tw_addr = acc_cur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         row    <= '0;
         col    <= '0;
         acc    <= '0;
      end else if (take) begin
         if (frame_end) begin
            active <= 1'b0;
            row    <= '0;
            col    <= '0;
            acc    <= '0;
         end else if (col_wrap) begin
            active <= 1'b1;
            row    <= row_cur + RW'(1);
            col    <= '0;
            acc    <= '0;
         end else begin
            active <= 1'b1;
            row    <= row_cur;
            col    <= col_cur + CW'(1);
            acc    <= acc_step;
         end
      end
   end

   // ---- ROM alignment: delay sample and flags to meet the twiddle ----
   logic                 a_vld, a_sof, a_last;
   logic signed [DW-1:0] a_re, a_im;

   generate
      if (TW_LAT == 0) begin : g_comb_rom
         assign a_vld  = take;
         assign a_sof  = start;
         assign a_last = take && frame_end;
         assign a_re   = in_re;
         assign a_im   = in_im;
      end else begin : g_reg_rom
         logic [TW_LAT-1:0]         vld_sr, sof_sr, last_sr;
         logic [TW_LAT-1:0][DW-1:0] re_sr, im_sr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_sr  <= '0;
               sof_sr  <= '0;
               last_sr <= '0;
            end else begin
               vld_sr[0]  <= take;
               sof_sr[0]  <= start;
               last_sr[0] <= take && frame_end;
               for (int i = 1; i < TW_LAT; i++) begin
                  vld_sr[i]  <= vld_sr[i-1];
                  sof_sr[i]  <= sof_sr[i-1];
                  last_sr[i] <= last_sr[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            re_sr[0] <= in_re;
            im_sr[0] <= in_im;
            for (int i = 1; i < TW_LAT; i++) begin
               re_sr[i] <= re_sr[i-1];
               im_sr[i] <= im_sr[i-1];
            end
         end

         assign a_vld  = vld_sr[TW_LAT-1];
         assign a_sof  = sof_sr[TW_LAT-1];
         assign a_last = last_sr[TW_LAT-1];
         assign a_re   = re_sr[TW_LAT-1];
         assign a_im   = im_sr[TW_LAT-1];
      end
   endgenerate

   // ---- Stage A: full-precision complex products ----
   logic signed [PW-1:0] xr, xi, wr, wi, mr, mi;
   logic signed [PW-1:0] p_re_p0, p_im_p0;
   logic                 vld_p0, sof_p0, last_p0;

   // tw_im is widened before negation so -(-2^17) stays representable.
   always_comb begin
      xr = PW'(a_re);
      xi = PW'(a_im);
      wr = PW'(tw_re);
      wi = (INVERSE != 0) ? -PW'(tw_im) : PW'(tw_im);
      mr = xr * wr - xi * wi;
      mi = xr * wi + xi * wr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0  <= 1'b0;
         sof_p0  <= 1'b0;
         last_p0 <= 1'b0;
      end else begin
         vld_p0  <= a_vld;
         sof_p0  <= a_vld && a_sof;
         last_p0 <= a_vld && a_last;
      end
   end

   always_ff @(posedge clk) begin
      if (a_vld) begin
         p_re_p0 <= mr;
         p_im_p0 <= mi;
      end
   end

   // ---- Stage B: round, saturate and register outputs ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_last  <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         out_valid <= vld_p0;
         out_sof   <= sof_p0;
         out_last  <= last_p0;
         if (vld_p0) begin
            out_re <= rnd_sat(p_re_p0);
            out_im <= rnd_sat(p_im_p0);
         end
      end
   end
endmodule

// File: tb/tb_twiddle_mult_108.sv
// Bench for twiddle_mult_108: combinational-ROM, registered-ROM and inverse instances share one stimulus.
module tb_twiddle_mult_108;
   localparam int NC = 27;
   localparam int NF = 108;
   localparam int NV = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, in_sof = 1'b0;
   logic signed [15:0] in_re = '0, in_im = '0;

   logic [10:0]        tw_addr0, tw_addr1, tw_addr2;
   logic signed [17:0] tw_re0, tw_im0, tw_re1, tw_im1, tw_re2, tw_im2;
   logic               out_valid0, out_sof0, out_last0;
   logic               out_valid1, out_sof1, out_last1;
   logic               out_valid2, out_sof2, out_last2;
   logic signed [15:0] out_re0, out_im0, out_re1, out_im1, out_re2, out_im2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int drv_cyc;
   int in_cyc[2*NF];

   typedef struct {int re; int im; logic sof; logic last; int cyc;} obs_t;
   obs_t q0[$], q1[$], q2[$];

   typedef struct {int frm; int idx; int xr; int xi; int er; int ei; int ir; int ii;} vec_t;
   vec_t vecs[NV];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Q10 ROM model: floor of the scaled value, tiny bias absorbs float noise at exact points.
   function automatic int rom_re_f(input int k);
      real a;
      a = 2.0 * 3.14159265358979323846 * real'(k) / 108.0;
      return $rtoi($floor(1024.0 * $cos(a) + 1.0e-9));
   endfunction
   function automatic int rom_im_f(input int k);
      real a;
      a = 2.0 * 3.14159265358979323846 * real'(k) / 108.0;
      return $rtoi($floor(-1024.0 * $sin(a) + 1.0e-9));
   endfunction

   assign tw_re0 = 18'(rom_re_f(int'(tw_addr0)));
   assign tw_im0 = 18'(rom_im_f(int'(tw_addr0)));
   assign tw_re2 = 18'(rom_re_f(int'(tw_addr2)));
   assign tw_im2 = 18'(rom_im_f(int'(tw_addr2)));
   always @(posedge clk) begin
      tw_re1 <= 18'(rom_re_f(int'(tw_addr1)));
      tw_im1 <= 18'(rom_im_f(int'(tw_addr1)));
   end

   twiddle_mult_108 #(.DW(16), .ROWS(4), .COLS(27), .TW_N(108), .TW_LAT(0), .INVERSE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_re(in_re), .in_im(in_im),
      .tw_addr(tw_addr0), .tw_re(tw_re0), .tw_im(tw_im0), .out_valid(out_valid0), .out_sof(out_sof0),
      .out_last(out_last0), .out_re(out_re0), .out_im(out_im0));
   twiddle_mult_108 #(.DW(16), .ROWS(4), .COLS(27), .TW_N(108), .TW_LAT(1), .INVERSE(0)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_re(in_re), .in_im(in_im),
      .tw_addr(tw_addr1), .tw_re(tw_re1), .tw_im(tw_im1), .out_valid(out_valid1), .out_sof(out_sof1),
      .out_last(out_last1), .out_re(out_re1), .out_im(out_im1));
   twiddle_mult_108 #(.DW(16), .ROWS(4), .COLS(27), .TW_N(108), .TW_LAT(0), .INVERSE(1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_re(in_re), .in_im(in_im),
      .tw_addr(tw_addr2), .tw_re(tw_re2), .tw_im(tw_im2), .out_valid(out_valid2), .out_sof(out_sof2),
      .out_last(out_last2), .out_re(out_re2), .out_im(out_im2));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int addr_of(input int i);
      return ((i / NC) * (i % NC)) % NF;
   endfunction

   function automatic int rsat(input longint p);
      longint n, q;
      n = p + 512;
      q = n / 1024;
      if ((n % 1024 != 0) && (n < 0)) q = q - 1;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   function automatic int mdl_re(input int xr, input int xi, input int k, input bit inv);
      longint wr, wi;
      wr = rom_re_f(k);
      wi = inv ? -rom_im_f(k) : rom_im_f(k);
      return rsat(longint'(xr) * wr - longint'(xi) * wi);
   endfunction
   function automatic int mdl_im(input int xr, input int xi, input int k, input bit inv);
      longint wr, wi;
      wr = rom_re_f(k);
      wi = inv ? -rom_im_f(k) : rom_im_f(k);
      return rsat(longint'(xr) * wi + longint'(xi) * wr);
   endfunction

   function automatic int find_vec(input int f, input int i);
      for (int k = 0; k < NV; k++)
         if (vecs[k].frm == f && vecs[k].idx == i) return k;
      return -1;
   endfunction

   task automatic drive(input bit v, input bit s, input int xr, input int xi, input int ea);
      @(posedge clk);
      #1;
      in_valid = v;
      in_sof   = s;
      in_re    = 16'(xr);
      in_im    = 16'(xi);
      drv_cyc  = cyc;
      @(negedge clk);
      if (ea >= 0) begin
         chk("tw_addr0", int'(tw_addr0), ea);
         chk("tw_addr1", int'(tw_addr1), ea);
         chk("tw_addr2", int'(tw_addr2), ea);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 0, 0, -1);
   endtask

   task automatic clear_q();
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   // Output capture, idle-flag and hold checks on the falling edge.
   int hold_re0 = 0, hold_im0 = 0;
   always @(negedge clk) begin
      if (out_valid0) q0.push_back('{int'(out_re0), int'(out_im0), out_sof0, out_last0, cyc});
      if (out_valid1) q1.push_back('{int'(out_re1), int'(out_im1), out_sof1, out_last1, cyc});
      if (out_valid2) q2.push_back('{int'(out_re2), int'(out_im2), out_sof2, out_last2, cyc});
      if (!rst_n) begin
         hold_re0 = 0;
         hold_im0 = 0;
      end
      if (out_valid0) begin
         hold_re0 = int'(out_re0);
         hold_im0 = int'(out_im0);
      end else begin
         chk("idle_flags0", int'({out_sof0, out_last0}), 0);
         chk("hold_re0", int'(out_re0), hold_re0);
         chk("hold_im0", int'(out_im0), hold_im0);
      end
      if (!out_valid1) chk("idle_flags1", int'({out_sof1, out_last1}), 0);
   end

   initial begin
      int k, er, ei, ir, ii, f, i, xr, xi, nsof, nlast, lastpos;

      vecs[0]  = '{0,   0, -32768, 12345, -32768, 12345, -32768, 12345};
      vecs[1]  = '{0,   5,  32767,    -1,  32767,    -1,  32767,    -1};
      vecs[2]  = '{0,  28,   1000,     0,    998,   -59,    998,    59};
      vecs[3]  = '{0,  36,      0,  1000,    500,   865,   -500,   865};
      vecs[4]  = '{0,  61,  32767, 32767,  32767, -1376,  -1376, 32767};
      vecs[5]  = '{0,  81,   -100,  -100,   -100,  -100,   -100,  -100};
      vecs[6]  = '{0,  90,    100,     0,      0,  -100,      0,   100};
      vecs[7]  = '{0,  99, -32768,     0,  32767,     0,  32767,     0};
      vecs[8]  = '{0, 107,   1024,     0,   -178,  1008,   -178, -1008};
      vecs[9]  = '{1,   0,      7,    -7,      7,    -7,      7,    -7};
      vecs[10] = '{1,  61, -32768, -32768, -32768, 1376,   1376, -32768};

      // Reset state
      #3;
      chk("rst_out_valid", int'({out_valid0, out_valid1, out_valid2}), 0);
      chk("rst_out_re", int'(out_re0), 0);
      chk("rst_out_im", int'(out_im2), 0);
      chk("rst_tw_addr", int'(tw_addr0), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(3);
      chk("post_rst_valid", int'({out_valid0, out_valid1, out_valid2}), 0);

      // Two back-to-back frames, table vectors overlaid on a constant (100,0) stream
      clear_q();
      for (int s = 0; s < 2 * NF; s++) begin
         f = s / NF;
         i = s % NF;
         k = find_vec(f, i);
         xr = (k >= 0) ? vecs[k].xr : 100;
         xi = (k >= 0) ? vecs[k].xi : 0;
         drive(1'b1, bit'(i == 0), xr, xi, addr_of(i));
         in_cyc[s] = drv_cyc;
      end
      idle(6);
      chk("p1_count0", q0.size(), 2 * NF);
      chk("p1_count1", q1.size(), 2 * NF);
      chk("p1_count2", q2.size(), 2 * NF);
      for (int j = 0; j < 2 * NF; j++) begin
         f = j / NF;
         i = j % NF;
         k = find_vec(f, i);
         if (k >= 0) begin
            er = vecs[k].er; ei = vecs[k].ei; ir = vecs[k].ir; ii = vecs[k].ii;
         end else begin
            er = mdl_re(100, 0, addr_of(i), 1'b0);
            ei = mdl_im(100, 0, addr_of(i), 1'b0);
            ir = mdl_re(100, 0, addr_of(i), 1'b1);
            ii = mdl_im(100, 0, addr_of(i), 1'b1);
         end
         if (j < q0.size()) begin
            chk($sformatf("re0[%0d]", j), q0[j].re, er);
            chk($sformatf("im0[%0d]", j), q0[j].im, ei);
            chk($sformatf("sof0[%0d]", j), int'(q0[j].sof), int'(i == 0));
            chk($sformatf("last0[%0d]", j), int'(q0[j].last), int'(i == NF - 1));
            chk($sformatf("lat0[%0d]", j), q0[j].cyc - in_cyc[j], 2);
         end
         if (j < q1.size()) begin
            chk($sformatf("re1[%0d]", j), q1[j].re, er);
            chk($sformatf("im1[%0d]", j), q1[j].im, ei);
            chk($sformatf("sof1[%0d]", j), int'(q1[j].sof), int'(i == 0));
            chk($sformatf("last1[%0d]", j), int'(q1[j].last), int'(i == NF - 1));
            chk($sformatf("lat1[%0d]", j), q1[j].cyc - in_cyc[j], 3);
         end
         if (j < q2.size()) begin
            chk($sformatf("re_inv[%0d]", j), q2[j].re, ir);
            chk($sformatf("im_inv[%0d]", j), q2[j].im, ii);
         end
      end

      // Gapped input, restart at sample 50, then unframed samples that must be dropped
      clear_q();
      for (int s = 0; s < 50; s++) begin
         drive(1'b1, bit'(s == 0), 100, 0, addr_of(s));
         drive(1'b0, 1'b0, 0, 0, -1);
      end
      for (int s = 0; s < NF; s++) begin
         drive(1'b1, bit'(s == 0), 100, 0, addr_of(s));
         drive(1'b0, 1'b0, 0, 0, -1);
      end
      for (int s = 0; s < 5; s++) begin
         drive(1'b1, 1'b0, 100, 0, -1);
         drive(1'b0, 1'b0, 0, 0, -1);
      end
      idle(6);
      chk("gap_count0", q0.size(), 50 + NF);
      chk("gap_count1", q1.size(), 50 + NF);
      chk("gap_count2", q2.size(), 50 + NF);
      nsof = 0; nlast = 0; lastpos = -1;
      for (int j = 0; j < q0.size(); j++) begin
         i = (j < 50) ? j : j - 50;
         if (q0[j].sof) nsof++;
         if (q0[j].last) begin nlast++; lastpos = j; end
         chk($sformatf("gap_re0[%0d]", j), q0[j].re, mdl_re(100, 0, addr_of(i), 1'b0));
         chk($sformatf("gap_im0[%0d]", j), q0[j].im, mdl_im(100, 0, addr_of(i), 1'b0));
      end
      chk("gap_sof_count", nsof, 2);
      chk("gap_last_count", nlast, 1);
      chk("gap_last_pos", lastpos, 50 + NF - 1);
      nlast = 0;
      for (int j = 0; j < q1.size(); j++) if (q1[j].last) nlast++;
      chk("gap_last_count1", nlast, 1);

      // Reset pulsed mid-frame
      drive(1'b1, 1'b1, 100, 0, 0);
      for (int s = 1; s < 20; s++) drive(1'b1, 1'b0, 100, 0, addr_of(s));
      @(posedge clk);
      #1;
      chk("pre_rst_valid0", int'(out_valid0), 1);
      chk("pre_rst_re0", int'(out_re0), 100);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midrst_valid", int'({out_valid0, out_valid1, out_valid2}), 0);
      chk("midrst_flags", int'({out_sof0, out_last0, out_sof1, out_last1, out_sof2, out_last2}), 0);
      chk("midrst_re", int'({out_re0, out_re1, out_re2}), 0);
      chk("midrst_im", int'({out_im0, out_im1, out_im2}), 0);
      chk("midrst_tw_addr", int'({tw_addr0, tw_addr1}), 0);
      @(posedge clk);
      #1;
      chk("in_rst_valid0", int'(out_valid0), 0);
      rst_n = 1'b1;
      clear_q();
      for (int s = 0; s < 10; s++) drive(1'b1, 1'b0, 100, 0, -1);
      idle(4);
      chk("nosof_count0", q0.size(), 0);
      chk("nosof_count1", q1.size(), 0);
      chk("nosof_count2", q2.size(), 0);
      for (int s = 0; s < NF; s++) drive(1'b1, bit'(s == 0), 100, 0, addr_of(s));
      idle(6);
      chk("refrm_count0", q0.size(), NF);
      chk("refrm_count1", q1.size(), NF);
      if (q0.size() == NF) begin
         chk("refrm_first_re", q0[0].re, 100);
         chk("refrm_first_sof", int'(q0[0].sof), 1);
         chk("refrm_last_flag", int'(q0[NF-1].last), 1);
         chk("refrm_last_re", q0[NF-1].re, -17);
      end
      if (q2.size() == NF) chk("refrm_inv_90_im", q2[90].im, 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/twiddle_mult_108.md
Name: twiddle_mult_108

Overview:
- Consumer of the 108-entry twiddle ROM (Q10 scale, 1.0 = 1024; entry k = e^(-j2πk/108)).
- Sits between the column-DFT and row-DFT stages of the 108-point (4×27) mixed-radix FFT in the PUSCH receive chain.
- Generates the ROM address sequence (row·col) mod 108 for a streamed frame.
- Multiplies each sample by its twiddle with rounding and saturation, and emits a framed output stream.

Parameters:
- DW, 16, data width per real/imag component (signed).
- ROWS, 4, rows per frame (row index = sample / COLS).
- COLS, 27, columns per frame; frame length = ROWS·COLS; ROWS·COLS ≤ 108·N not required, but ROWS ≤ 108.
- TW_N, 108, twiddle table length (modulus).
- TW_LAT, 0, ROM read latency in cycles. 0 means a combinational ROM, 1 means a registered ROM (TW_FF=1).
- INVERSE, 0, 1 = conjugate the twiddle (negate tw_im) for IFFT use.

Ports:
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_sof  in  1  first sample of frame, qualified by in_valid
- in_re  in  DW  input real, signed
- in_im  in  DW  input imag, signed
- tw_addr  out  11  ROM address
- tw_re  in  18  ROM twiddle real, signed Q10
- tw_im  in  18  ROM twiddle imag, signed Q10
- out_valid  out  1  output valid
- out_sof  out  1  first output sample of frame
- out_last  out  1  last output sample of frame
- out_re  out  DW  output real
- out_im  out  DW  output imag

Behaviour:
- Reset: all outputs 0, counters row/col/acc 0, pipeline valids cleared, and the frame is idle until in_sof.
- Address generation:
  - tw_addr is driven combinationally from acc, which is valid in the same cycle as the accepted sample.
  - When in_valid=1 && in_sof=1, the sample uses row=0, col=0, tw_addr=0. The next-sample state is col=1, row=0, acc=0.
  - On each accepted sample (in_valid=1), col advances. When col wraps COLS-1 → 0, row increments and acc resets to 0. Otherwise acc += row, and if the result is ≥ TW_N, TW_N is subtracted.
  - tw_addr = acc, always < 108.
- Frame end: after sample ROWS·COLS-1 the block returns to idle. Samples with in_valid=1 but no in_sof while idle are dropped (no output).
- in_sof mid-frame: the current frame is abandoned and restarts at index 0. Samples already in the pipeline still drain, but the abandoned frame never gets out_last.
- in_valid=0 cycles stall the counters. There is no backpressure; the output cadence mirrors the input.
- Data alignment: input data and sof/last flags are delayed TW_LAT cycles to meet the ROM data.
- Twiddle conditioning: if INVERSE=1, wi = -tw_im, else wi = tw_im.
- Complex multiply (full precision, 2·DW+… bits, no intermediate truncation):
  - re = xr·wr − xi·wi
  - im = xr·wi + xi·wr
- Scaling: result = (p + 512) >>> 10 (arithmetic shift, round half up), then saturate to [−2^(DW−1), 2^(DW−1)−1].
- Pipeline:
  - Stage A registers the products.
  - Stage B registers the round/saturate result.
  - Total latency from in_valid to out_valid = TW_LAT + 2 cycles. Throughput is 1 sample/cycle.
- Flags:
  - out_sof is asserted with the output of sample index 0.
  - out_last is asserted with index ROWS·COLS−1.
  - Both are 0 whenever out_valid=0.
- out_re/out_im hold their last value when out_valid=0.
- Reset asserted mid-frame: immediate clear, and pending outputs are discarded.

Test Plan:
- TW_LAT=0, full frame of 108 samples, in_re=100, in_im=0 → tw_addr sequence is 0×27, then 0,1,…,26, then 0,2,…,52, then 0,3,…,78 mod 108. Sample 90 (row 3, col 9, addr 27) → out (0,−100).
- Row-0 samples (addr 0, twiddle 1024+j0), input (−32768, 12345) → output exactly (−32768, 12345), latency 2.
- Sample 61 (addr 14, twiddle 702−j745), input (32767, 32767) → out_re saturates to 32767, out_im = −1376.
- TW_LAT=1 with a registered ROM model → identical outputs to the TW_LAT=0 case, latency 3; out_sof/out_last are aligned with the first and 108th outputs.
- in_valid gaps every other cycle, plus in_sof re-asserted at sample 50 → counters restart (tw_addr=0), exactly one out_last per completed frame, no output for post-frame samples lacking in_sof.
- INVERSE=1, sample 90, input (100, 0) → (0, +100). rst_n pulsed low mid-frame → all outputs 0 immediately and no outputs until the next in_sof.
